// File: rtl/mux_pkg.sv
// Shared widths, state encoding and helpers for the mux select arbiter.
package mux_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  function automatic logic [NCH-1:0] sel2onehot(input logic [SEL_W-1:0] s);
    return NCH'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: searches prio+1, prio+2, prio+3, prio (mod 4),
// and the first requester found wins.
module rr_pick
  import mux_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] prio,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    any = 1'b0;
    win = prio;
    idx = '0;
    for (int k = 1; k <= int'(NCH); k++) begin
      idx = prio + SEL_W'(k);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin burst arbiter driving the registered sel/valid of a 4:1 mux,
// with a per-channel ack on every transferred beat.
module mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   last,
  input  logic             ready,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic [NCH-1:0]   ack
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic             xfer;
  logic             abort;
  logic             burst_end;

  // prio_q equals sel_q throughout a grant, so one picker serves both
  // the idle start and the end-of-grant handover.
  rr_pick u_pick (
    .req  (req),
    .prio (prio_q),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign xfer      = valid_q & ready;
  assign abort     = valid_q & ~ready & ~req[sel_q];
  assign burst_end = xfer & (last[sel_q] | (cnt_q == CNT_W'(MAX_BURST - 1)));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANT;
          sel_d   = pick_win;
          prio_d  = pick_win;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Handover with no bubble when someone else (or only us) is waiting.
        if (burst_end || abort) begin
          cnt_d = '0;
          if (pick_any) begin
            sel_d  = pick_win;
            prio_d = pick_win;
          end else begin
            state_d = ARB_IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      prio_q  <= SEL_W'(NCH - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel   = sel_q;
  assign valid = valid_q;
  assign ack   = sel2onehot(sel_q) & {NCH{xfer & ~rst}};

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with hand-computed per-cycle expectations.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic       ready;
  logic [1:0] sel;
  logic       valid;
  logic [3:0] ack;

  int n_run;
  int n_fail;

  mux_sel_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .last  (last),
    .ready (ready),
    .sel   (sel),
    .valid (valid),
    .ack   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (observed running, expected done)");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check outputs for the current cycle (inputs already applied), then advance.
  task automatic cyc(input string tag, input logic ev, input logic [1:0] es,
                     input logic [3:0] ea);
    #1;
    n_run++;
    assert (valid === ev) else begin
      n_fail++;
      $error("FAIL %s valid: observed %b expected %b", tag, valid, ev);
    end
    n_run++;
    assert (ack === ea) else begin
      n_fail++;
      $error("FAIL %s ack: observed %b expected %b", tag, ack, ea);
    end
    if (ev) begin
      n_run++;
      assert (sel === es) else begin
        n_fail++;
        $error("FAIL %s sel: observed %0d expected %0d", tag, sel, es);
      end
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1; req = '0; last = '0; ready = 1'b1;
    step();
    step();
    // Reset state, with ready high: ack must stay low.
    n_run++;
    assert (sel === 2'b00) else begin
      n_fail++; $error("FAIL reset_sel: observed %0d expected 0", sel);
    end
    cyc("reset", 1'b0, 2'd0, 4'b0000);
    rst = 1'b0;

    // Two requesters, full 4-beat bursts, no bubble at the handover.
    req = 4'b0101; ready = 1'b1; last = '0;
    cyc("t1_idle", 1'b0, 2'd0, 4'b0000);
    for (int i = 0; i < 4; i++) cyc("t1_ch0", 1'b1, 2'd0, 4'b0001);
    for (int i = 0; i < 4; i++) cyc("t1_ch2", 1'b1, 2'd2, 4'b0100);
    cyc("t1_back0", 1'b1, 2'd0, 4'b0001);

    // All requesting, last on every beat: one-beat rotation.
    do_reset();
    req = 4'b1111; last = 4'b1111; ready = 1'b1;
    cyc("t2_idle", 1'b0, 2'd0, 4'b0000);
    cyc("t2_g0", 1'b1, 2'd0, 4'b0001);
    cyc("t2_g1", 1'b1, 2'd1, 4'b0010);
    cyc("t2_g2", 1'b1, 2'd2, 4'b0100);
    cyc("t2_g3", 1'b1, 2'd3, 4'b1000);
    cyc("t2_g0b", 1'b1, 2'd0, 4'b0001);
    cyc("t2_g1b", 1'b1, 2'd1, 4'b0010);

    // Channel 1 stalled for 3 cycles after 2 beats; exactly 2 beats remain.
    do_reset();
    req = 4'b0010; ready = 1'b1;
    cyc("t3_idle", 1'b0, 2'd0, 4'b0000);
    cyc("t3_b0", 1'b1, 2'd1, 4'b0010);
    cyc("t3_b1", 1'b1, 2'd1, 4'b0010);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t3_stall", 1'b1, 2'd1, 4'b0000);
    ready = 1'b1;
    cyc("t3_b2", 1'b1, 2'd1, 4'b0010);
    req = 4'b0000;
    cyc("t3_b3", 1'b1, 2'd1, 4'b0010);
    cyc("t3_idle_after", 1'b0, 2'd1, 4'b0000);
    n_run++;
    assert (sel === 2'd1) else begin
      n_fail++; $error("FAIL t3_sel_hold: observed %0d expected 1", sel);
    end

    // Sole requester 3 is re-granted across burst boundaries with no gap.
    do_reset();
    req = 4'b1000; ready = 1'b1;
    cyc("t4_idle", 1'b0, 2'd0, 4'b0000);
    for (int i = 0; i < 10; i++) cyc("t4_ch3", 1'b1, 2'd3, 4'b1000);

    // Withdrawal of channel 2 while stalled: abort to next requester, then idle.
    do_reset();
    req = 4'b0100; ready = 1'b1;
    cyc("t5_idle", 1'b0, 2'd0, 4'b0000);
    cyc("t5_b0", 1'b1, 2'd2, 4'b0100);
    ready = 1'b0;
    cyc("t5_stall", 1'b1, 2'd2, 4'b0000);
    req = 4'b0001;
    cyc("t5_withdraw", 1'b1, 2'd2, 4'b0000);
    cyc("t5_to_ch0", 1'b1, 2'd0, 4'b0000);
    ready = 1'b1;
    cyc("t5_ch0_beat", 1'b1, 2'd0, 4'b0001);
    req = 4'b0000; ready = 1'b0;
    cyc("t5_withdraw0", 1'b1, 2'd0, 4'b0000);
    cyc("t5_idle_end", 1'b0, 2'd0, 4'b0000);

    // Reset on the 2nd beat of a burst.
    do_reset();
    req = 4'b0110; ready = 1'b1;
    cyc("t6_idle", 1'b0, 2'd0, 4'b0000);
    cyc("t6_b0", 1'b1, 2'd1, 4'b0010);
    rst = 1'b1;
    cyc("t6_rst_beat", 1'b1, 2'd1, 4'b0000);
    rst = 1'b0;
    n_run++;
    assert (sel === 2'd0) else begin
      n_fail++; $error("FAIL t6_rst_sel: observed %0d expected 0", sel);
    end
    cyc("t6_after_rst", 1'b0, 2'd0, 4'b0000);
    cyc("t6_regrant", 1'b1, 2'd1, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that sits directly upstream of the team's 4:1 2-bit mux and drives its `sel` input. Four producer channels raise requests; the arbiter grants one channel at a time for a burst of up to `MAX_BURST` beats, presents a registered `sel`/`valid` pair to the mux/consumer side, and returns a per-channel `ack` on every transferred beat. The rotating pointer gives fair service with no bubbles between back-to-back grants.

## Interface
- `MAX_BURST`, default 4: maximum beats per grant before forced rotation; legal range 1..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input 4: per-channel request; bit i high means channel i has a beat available.
- `last` input 4: per-channel end-of-burst flag, qualified only for the granted channel on a transferring beat.
- `ready` input 1: consumer accepts the beat presented this cycle.
- `sel` output 2: registered select to the mux; the granted channel index.
- `valid` output 1: registered; the beat on the mux output is valid.
- `ack` output 4: one-hot pulse `onehot(sel) & {4{valid & ready}}`; combinational from registered state and `ready`.

## Operation
- States: IDLE (no grant, `valid=0`) and GRANT (`valid=1`).
- Pointer `prio` holds the last granted channel; the search order is `prio+1, prio+2, prio+3, prio` (mod 4), with the first requester winning.
- IDLE: if `|req`, the next cycle goes to GRANT with `sel`=winner, `valid=1`, `beat_cnt=0`, `prio`=winner. Otherwise it stays in IDLE and `sel` holds its old value.
- GRANT, beat transfers (`valid & ready`): `ack[sel]` pulses and `beat_cnt` increments.
- End of grant occurs on a transferring beat with `last[sel]=1` or `beat_cnt==MAX_BURST-1`.
  - If any `req` is high at end of grant, re-arbitrate in the same cycle using the updated pointer (=current `sel`). The next cycle is GRANT for the winner with no bubble.
  - The current channel is lowest priority and is re-granted only if it is the sole requester.
  - If no `req` is high, the next state is IDLE.
- GRANT with `!ready`: hold `sel`, `valid`, `beat_cnt`; no `ack`.
- Withdrawal (`valid & !ready & !req[sel]`): protocol violation by the producer. The grant aborts with no `ack`, and the next cycle re-arbitrates exactly as at end of grant.
- `beat_cnt` width is 4 bits; it never wraps because the grant ends at `MAX_BURST-1`.
- `last` bits of non-granted channels are ignored.

## Timing
- Reset values: `sel=2'b00`, `valid=0`, `ack=0`, state IDLE, `prio=2'd3` (so channel 0 wins first), `beat_cnt=0`.
- `rst` asserted mid-burst: the next edge returns all state to reset values. `ack` is forced to 0 in any cycle where `rst` is high.
- Latency from `req` rising in IDLE to `valid`: 1 cycle.
- Throughput: 1 beat/cycle with `ready` held high, including across grant boundaries.
- `sel` changes only at the edge following an end-of-grant or abort. It is stable for the whole of every grant.

## Structure
- Shared package `mux_pkg` holds:
  - `SEL_W=2` and `NCH=4`.
  - State typedef `arb_state_t {ARB_IDLE, ARB_GRANT}`.
  - Function `sel2onehot`.
- Sub-module `rr_pick`: a combinational rotating-priority encoder.
  - Inputs: `req[3:0]`, `prio[1:0]`.
  - Outputs: `any`, `win[1:0]`.
  - Instantiated once; the arbiter FSM, counter and output registers stay in the top module.

## Test plan
- Reset then `req=4'b0101`, `ready=1`, `last` low, `MAX_BURST=4`: `valid` rises 1 cycle later with `sel=0`. `ack=4'b0001` is seen for 4 cycles, then `sel=2` follows with no gap, then back to `sel=0`.
- All four `req` high, `last` asserted on every beat, `ready=1`: grants rotate 0,1,2,3,0,… one beat each, with `ack` walking one-hot every cycle.
- Channel 1 granted, `ready` low for 3 cycles mid-burst: `sel=1` and `valid=1` hold, `ack=0`, and `beat_cnt` is unchanged. The burst resumes and completes its remaining beats.
- Sole requester channel 3, `MAX_BURST=4`, `last` never set: after 4 beats `sel` stays 3 with no bubble (re-grant), and `ack[3]` pulses continuously.
- Channel 2 granted, `ready=0`, then `req[2]` drops: the next cycle has no `ack`, and the grant moves to the next requester or goes to IDLE with `valid=0`.
- `rst` pulsed on the 2nd beat of a burst: the next cycle shows `valid=0`, `sel=0`, `ack=0`. With requests held, the first grant after reset goes to the lowest-index requester.
